// File: rtl/carrier_nco.sv
// Carrier-loop NCO: the center frequency plus the loop-filter correction drives a 32-bit phase
// accumulator. It also paces the detectors and the loop filter with the ddcSync decimation strobe.
module carrier_nco #(
  parameter logic [11:0] BASE_ADDR = 12'h100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr0,
  input  logic        wr1,
  input  logic        wr2,
  input  logic        wr3,
  input  logic [11:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [31:0] carrierFreqOffset,
  input  logic        carrierFreqEn,
  output logic [15:0] ncoPhase,
  output logic [31:0] freqWord,
  output logic        ddcSync
);

  localparam logic [3:0] OFS_CENTER = 4'h0;
  localparam logic [3:0] OFS_CTRL   = 4'h4;
  localparam logic [3:0] OFS_DEC    = 4'h8;
  localparam logic [3:0] OFS_FREQ   = 4'hC;

  logic        selected;
  logic [3:0]  regOfs;
  logic [3:0]  byteWr;
  logic        decWr;
  logic        phaseClear;

  logic [31:0] centerFreq;
  logic        offsetEnable;
  logic        invertOffset;
  logic [15:0] decRatio;

  logic [31:0] offsetReg;
  logic [31:0] term;
  logic [31:0] phaseAcc;
  logic [15:0] decCount;

  assign selected   = (addr[11:4] == BASE_ADDR[11:4]);
  assign regOfs     = addr[3:0];
  assign byteWr     = selected ? {wr3, wr2, wr1, wr0} : 4'b0000;
  assign decWr      = (regOfs == OFS_DEC) && (|byteWr);
  // phaseClear is a command, not stored state: it acts on the edge that samples the write.
  assign phaseClear = (regOfs == OFS_CTRL) && byteWr[0] && din[2];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      centerFreq   <= '0;
      offsetEnable <= 1'b0;
      invertOffset <= 1'b0;
      decRatio     <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (byteWr[b] && regOfs == OFS_CENTER) centerFreq[8*b +: 8] <= din[8*b +: 8];
      end
      for (int b = 0; b < 2; b++) begin
        if (byteWr[b] && regOfs == OFS_DEC) decRatio[8*b +: 8] <= din[8*b +: 8];
      end
      if (byteWr[0] && regOfs == OFS_CTRL) begin
        offsetEnable <= din[0];
        invertOffset <= din[1];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    term = '0;
    if (offsetEnable) term = invertOffset ? -offsetReg : offsetReg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offsetReg <= '0;
      freqWord  <= '0;
      phaseAcc  <= '0;
    end else begin
      if (carrierFreqEn) offsetReg <= carrierFreqOffset;
      freqWord <= centerFreq + term;
      if (phaseClear) phaseAcc <= '0;
      else            phaseAcc <= phaseAcc + freqWord;
    end
  end

  // A decRatio write zeroes the counter so the next edge starts a fresh period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decCount <= '0;
      ddcSync  <= 1'b0;
    end else if (decWr) begin
      decCount <= '0;
      ddcSync  <= 1'b0;
    end else if (decCount == 16'd0) begin
      decCount <= decRatio;
      ddcSync  <= 1'b1;
    end else begin
      decCount <= decCount - 16'd1;
      ddcSync  <= 1'b0;
    end
  end

  assign ncoPhase = phaseAcc[31:16];

  always_comb begin
    dout = '0;
    if (selected) begin
      case (regOfs)
        OFS_CENTER: dout = centerFreq;
        OFS_CTRL:   dout = {30'd0, invertOffset, offsetEnable};
        OFS_DEC:    dout = {16'd0, decRatio};
        OFS_FREQ:   dout = freqWord;
        default:    dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_carrier_nco.sv
// Self-checking bench for carrier_nco: directed scenarios plus randomized traffic, compared
// against a behavioural model of frequency, phase and strobe timing.
module tb_carrier_nco;

  logic        clk;
  logic        reset;
  logic        wr0, wr1, wr2, wr3;
  logic [11:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] carrierFreqOffset;
  logic        carrierFreqEn;
  logic [15:0] ncoPhase;
  logic [31:0] freqWord;
  logic        ddcSync;

  int numChecks = 0;
  int numErrors = 0;

  // Reference model state.
  logic [31:0] mCenter;
  logic        mEnable;
  logic        mInvert;
  logic [15:0] mDecRatio;
  logic [31:0] mOffset;
  logic [31:0] mFreq;
  logic [31:0] mPhase;
  logic        mSync;
  int          mNextK;

  carrier_nco dut (
    .clk(clk), .reset(reset),
    .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
    .addr(addr), .din(din), .dout(dout),
    .carrierFreqOffset(carrierFreqOffset), .carrierFreqEn(carrierFreqEn),
    .ncoPhase(ncoPhase), .freqWord(freqWord), .ddcSync(ddcSync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mCenter = '0; mEnable = 1'b0; mInvert = 1'b0; mDecRatio = '0;
    mOffset = '0; mFreq = '0; mPhase = '0; mSync = 1'b0; mNextK = 0;
  endtask

  function automatic logic [31:0] expRead(input logic [11:0] a);
    if (a[11:4] != 8'h10) return 32'd0;
    case (a[3:0])
      4'h0:    return mCenter;
      4'h4:    return {30'd0, mInvert, mEnable};
      4'h8:    return {16'd0, mDecRatio};
      4'hC:    return mFreq;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: capture the inputs the DUT samples, advance the model, compare after the edge.
  task automatic tick();
    logic [3:0]  wrs;
    logic        sel;
    logic [3:0]  ofs;
    logic [31:0] d, off, termV, newFreq, newPhase;
    logic        en, clr, decW;
    wrs = {wr3, wr2, wr1, wr0};
    sel = (addr[11:4] == 8'h10);
    ofs = addr[3:0];
    d = din; en = carrierFreqEn; off = carrierFreqOffset;
    @(posedge clk);
    termV    = !mEnable ? 32'd0 : (mInvert ? 32'd0 - mOffset : mOffset);
    newFreq  = mCenter + termV;
    clr      = sel && ofs == 4'h4 && wrs[0] && d[2];
    newPhase = clr ? 32'd0 : mPhase + mFreq;
    decW     = sel && ofs == 4'h8 && (|wrs);
    if (decW) begin
      mSync = 1'b0; mNextK = 0;
    end else begin
      mSync = (mNextK % (int'(mDecRatio) + 1)) == 0;
      mNextK++;
    end
    if (sel) begin
      for (int b = 0; b < 4; b++) begin
        if (wrs[b] && ofs == 4'h0) mCenter[8*b +: 8] = d[8*b +: 8];
        if (wrs[b] && ofs == 4'h8 && b < 2) mDecRatio[8*b +: 8] = d[8*b +: 8];
      end
      if (wrs[0] && ofs == 4'h4) begin
        mEnable = d[0]; mInvert = d[1];
      end
    end
    if (en) mOffset = off;
    mFreq = newFreq;
    mPhase = newPhase;
    #1;
    check("freqWord", freqWord, mFreq);
    check("ncoPhase", {16'd0, ncoPhase}, {16'd0, mPhase[31:16]});
    check("ddcSync", {31'd0, ddcSync}, {31'd0, mSync});
  endtask

  task automatic regWrite(input logic [11:0] a, input logic [31:0] d, input logic [3:0] strb);
    addr = a; din = d;
    {wr3, wr2, wr1, wr0} = strb;
    tick();
    {wr3, wr2, wr1, wr0} = 4'b0000;
  endtask

  task automatic regRead(input string tag, input logic [11:0] a);
    addr = a;
    #1;
    check(tag, dout, expRead(a));
  endtask

  task automatic checkAllZeroOutputs(input string tag);
    check({tag, "_freq"}, freqWord, 32'd0);
    check({tag, "_phase"}, {16'd0, ncoPhase}, 32'd0);
    check({tag, "_sync"}, {31'd0, ddcSync}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    {wr3, wr2, wr1, wr0} = 4'b0000;
    addr = 12'h100; din = '0;
    carrierFreqOffset = '0; carrierFreqEn = 1'b0;
    modelReset();
    #2;
    checkAllZeroOutputs("rst0");
    regRead("rst_center", 12'h100);
    regRead("rst_ctrl", 12'h104);
    regRead("rst_dec", 12'h108);
    regRead("rst_freq", 12'h10C);
    @(negedge clk);
    reset = 1'b0;

    // Center frequency alone, decRatio 0: strobe held high, phase steps 0x0100 per clock.
    regWrite(12'h100, 32'h0100_0000, 4'hF);
    tick();
    check("center_freq", freqWord, 32'h0100_0000);
    for (int i = 0; i < 260; i++) tick();

    // Offset added, then subtracted.
    regWrite(12'h104, 32'h1, 4'h1);
    carrierFreqOffset = 32'h0000_1000; carrierFreqEn = 1'b1;
    tick();
    carrierFreqEn = 1'b0;
    tick();
    check("offset_add", freqWord, 32'h0100_1000);
    regWrite(12'h104, 32'h3, 4'h1);
    tick();
    check("offset_inv", freqWord, 32'h00FF_F000);
    regRead("ctrl_rb", 12'h104);

    // Modulo wrap of the frequency sum.
    regWrite(12'h100, 32'hFFFF_FFFF, 4'hF);
    regWrite(12'h104, 32'h1, 4'h1);
    carrierFreqOffset = 32'd2; carrierFreqEn = 1'b1;
    tick();
    carrierFreqEn = 1'b0;
    tick();
    check("freq_wrap", freqWord, 32'h0000_0001);
    for (int i = 0; i < 4; i++) tick();

    // Decimation period 4, then restart at period 2 in mid-count.
    regWrite(12'h108, 32'd3, 4'h3);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("dec3_pattern", {31'd0, ddcSync}, {31'd0, (i % 4) == 0});
    end
    tick(); tick();
    regWrite(12'h108, 32'd1, 4'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("dec1_pattern", {31'd0, ddcSync}, {31'd0, (i % 2) == 0});
    end
    regRead("dec_rb", 12'h108);

    // Phase clear wins over the accumulate on its own edge.
    regWrite(12'h100, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 5; i++) tick();
    regWrite(12'h104, 32'h5, 4'h1);
    check("phase_clear", {16'd0, ncoPhase}, 32'd0);
    regRead("ctrl_clr_rb", 12'h104);
    tick();
    check("phase_resume", {16'd0, ncoPhase}, {16'd0, freqWord[31:16]});

    // Randomized traffic: loop corrections every cycle, interleaved register writes and reads.
    for (int i = 0; i < 600; i++) begin
      logic [11:0] targets [6];
      logic [11:0] a;
      logic [31:0] d;
      targets = '{12'h100, 12'h104, 12'h108, 12'h10C, 12'h102, 12'h204};
      carrierFreqEn = 1'($urandom_range(0, 1));
      carrierFreqOffset = $urandom();
      if ($urandom_range(0, 7) == 0) begin
        a = targets[$urandom_range(0, 5)];
        d = $urandom();
        if (a == 12'h108) d = 32'($urandom_range(0, 5));
        regWrite(a, d, 4'($urandom_range(1, 15)));
      end else begin
        tick();
      end
      if ($urandom_range(0, 15) == 0) regRead("rand_read", targets[$urandom_range(0, 5)]);
    end
    carrierFreqEn = 1'b0;

    // Asynchronous reset mid-cycle.
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    checkAllZeroOutputs("async_rst");
    regRead("arst_center", 12'h100);
    regRead("arst_ctrl", 12'h104);
    regRead("arst_dec", 12'h108);
    regRead("arst_freq", 12'h10C);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_sync", {31'd0, ddcSync}, 32'd1);
    regWrite(12'h100, 32'hCAFE_0001, 4'hF);
    regRead("sel_read", 12'h100);
    regRead("unsel_read", 12'h200);
    regRead("unmapped_read", 12'h10E);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
